// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs 64-bit beats into padded 1024-bit blocks.
// Optional SHA512_PADDER_ERR_EN adds a sticky err_o for msg_bytes_i > 8.
module sha512_padder #(
    parameter int BlockWidth = 1024,
    parameter int LenWidth   = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [63:0]           msg_data_i,
    input  logic                  msg_valid_i,
    input  logic                  msg_last_i,
    input  logic [3:0]            msg_bytes_i,
    output logic                  msg_ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    input  logic                  block_ready_i,
    output logic                  block_first_o,
    output logic                  block_last_o,
    output logic                  err_o
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] PAD  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]          state_q;
    logic [3:0]          cnt_q;
    logic [LenWidth-1:0] bitlen_q;
    logic                marker_pending_q;
    logic                pad_active_q;
    logic                final_blk_q;
    logic                first_flag_q;
    logic [63:0]         buf_q [16];

    logic                accept;
    logic                bytes_err;
    logic [3:0]          nb;
    logic [63:0]         last_word;
    logic [127:0]        len_ext;

    assign accept    = msg_valid_i & msg_ready_o;
    assign bytes_err = msg_bytes_i > 4'd8;
    assign nb        = bytes_err ? 4'd8 : msg_bytes_i;
    assign len_ext   = 128'(bitlen_q);

    assign msg_ready_o   = state_q == FILL;
    assign block_valid_o = state_q == EMIT;
    assign block_first_o = first_flag_q;
    assign block_last_o  = final_blk_q & (state_q == EMIT);

    // Keep the valid bytes of the final beat and place the 0x80 marker after them.
    always_comb begin
        last_word = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(nb))
                last_word[63-8*i -: 8] = msg_data_i[63-8*i -: 8];
            else if (i == int'(nb))
                last_word[63-8*i -: 8] = 8'h80;
        end
    end

    // Flatten the word buffer onto the block bus, word 0 in the top bits.
    always_comb begin
        block_o = '0;
        for (int i = 0; i < 16; i++)
            block_o[BlockWidth-1-64*i -: 64] = buf_q[i];
    end

    // Fill / pad / emit sequencing and block buffer updates.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= FILL;
            cnt_q            <= '0;
            bitlen_q         <= '0;
            marker_pending_q <= 1'b0;
            pad_active_q     <= 1'b0;
            final_blk_q      <= 1'b0;
            first_flag_q     <= 1'b1;
            for (int i = 0; i < 16; i++)
                buf_q[i] <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (accept) begin
                        if (!msg_last_i) begin
                            buf_q[cnt_q] <= msg_data_i;
                            bitlen_q     <= bitlen_q + LenWidth'(64);
                            if (cnt_q == 4'd15)
                                state_q <= EMIT;
                            else
                                cnt_q <= cnt_q + 4'd1;
                        end else begin
                            buf_q[cnt_q]     <= last_word;
                            bitlen_q         <= bitlen_q + LenWidth'({nb, 3'b000});
                            marker_pending_q <= nb == 4'd8;
                            pad_active_q     <= 1'b1;
                            if (cnt_q == 4'd15) begin
                                state_q <= EMIT;
                            end else begin
                                cnt_q   <= cnt_q + 4'd1;
                                state_q <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    // final_blk_q set at word 14 marks that the length is being placed here.
                    if (marker_pending_q) begin
                        buf_q[cnt_q]     <= 64'h8000_0000_0000_0000;
                        marker_pending_q <= 1'b0;
                    end else if (cnt_q == 4'd14) begin
                        buf_q[cnt_q] <= len_ext[127:64];
                        final_blk_q  <= 1'b1;
                    end else if (cnt_q == 4'd15 && final_blk_q) begin
                        buf_q[cnt_q] <= len_ext[63:0];
                    end else begin
                        buf_q[cnt_q] <= '0;
                    end
                    if (cnt_q == 4'd15)
                        state_q <= EMIT;
                    else
                        cnt_q <= cnt_q + 4'd1;
                end
                EMIT: begin
                    if (block_ready_i) begin
                        cnt_q        <= '0;
                        first_flag_q <= 1'b0;
                        for (int i = 0; i < 16; i++)
                            buf_q[i] <= '0;
                        if (final_blk_q) begin
                            bitlen_q     <= '0;
                            pad_active_q <= 1'b0;
                            final_blk_q  <= 1'b0;
                            first_flag_q <= 1'b1;
                            state_q      <= FILL;
                        end else if (pad_active_q) begin
                            state_q <= PAD;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef SHA512_PADDER_ERR_EN
    logic err_q;

    // Sticky flag for an out-of-range byte count on a final beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            err_q <= 1'b0;
        else if (accept && msg_last_i && bytes_err)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sha512_padder.sv
// Self-checking bench for sha512_padder.
// Expected blocks come from a byte-level padding model and a scoreboard queue.
module tb_sha512_padder;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   msg_data;
    logic          msg_valid;
    logic          msg_last;
    logic [3:0]    msg_bytes;
    logic          msg_ready;
    logic [1023:0] block;
    logic          block_valid;
    logic          block_ready;
    logic          block_first;
    logic          block_last;
    logic          err;

    typedef struct {
        logic [1023:0] data;
        logic          first;
        logic          last;
    } blk_t;

    blk_t          exp_q[$];
    logic [7:0]    msg[$];
    logic [1023:0] last_blk;
    int            errors = 0;
    int            checks = 0;

    sha512_padder dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .msg_data_i    (msg_data),
        .msg_valid_i   (msg_valid),
        .msg_last_i    (msg_last),
        .msg_bytes_i   (msg_bytes),
        .msg_ready_o   (msg_ready),
        .block_o       (block),
        .block_valid_o (block_valid),
        .block_ready_i (block_ready),
        .block_first_o (block_first),
        .block_last_o  (block_last),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    task automatic set_rand_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++)
            msg.push_back(8'($urandom));
    endtask

    task automatic build_expected(input int len);
        int            plen;
        logic [7:0]    pad[];
        logic [127:0]  bits;
        blk_t          b;
        plen = ((len + 17 + 127) / 128) * 128;
        pad  = new[plen];
        for (int i = 0; i < plen; i++)
            pad[i] = 8'h00;
        for (int i = 0; i < len; i++)
            pad[i] = msg[i];
        pad[len] = 8'h80;
        bits = 128'(len);
        bits = bits << 3;
        for (int k = 0; k < 16; k++)
            pad[plen-16+k] = bits[127-8*k -: 8];
        for (int n = 0; n < plen / 128; n++) begin
            for (int j = 0; j < 128; j++)
                b.data[1023-8*j -: 8] = pad[n*128+j];
            b.first = n == 0;
            b.last  = n == plen / 128 - 1;
            exp_q.push_back(b);
        end
    endtask

    task automatic run_msg(input string name, input int len,
                           input int stall, input int force_nb);
        int            nbeats;
        int            b;
        int            cycles;
        int            stall_left;
        int            nb;
        int            bad;
        logic          seen;
        logic [1023:0] snap;
        logic          sf;
        logic          sl;
        logic [63:0]   w;
        blk_t          e;
        build_expected(len);
        nbeats     = (len == 0) ? 1 : (len + 7) / 8;
        b          = 0;
        cycles     = 0;
        seen       = 1'b0;
        stall_left = 0;
        while ((b < nbeats || exp_q.size() != 0) && cycles < 4000) begin
            @(negedge clk);
            cycles++;
            if (b < nbeats) begin
                w  = {$urandom, $urandom};
                nb = (b == nbeats - 1) ? len - 8 * b : 8;
                for (int k = 0; k < nb; k++)
                    w[63-8*k -: 8] = msg[8*b+k];
                msg_data  = w;
                msg_valid = 1'b1;
                msg_last  = b == nbeats - 1;
                if (b == nbeats - 1)
                    msg_bytes = (force_nb >= 0) ? 4'(force_nb) : 4'(nb);
                else
                    msg_bytes = 4'($urandom_range(0, 15));
                if (msg_ready)
                    b++;
            end else begin
                msg_valid = 1'b0;
                msg_last  = 1'b0;
            end
            if (block_valid) begin
                checks++;
                if (msg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_in_emit got %b want 0", name, msg_ready);
                end
                if (!seen) begin
                    seen       = 1'b1;
                    snap       = block;
                    sf         = block_first;
                    sl         = block_last;
                    stall_left = stall;
                end
                if (stall_left > 0) begin
                    stall_left--;
                    block_ready = 1'b0;
                    checks++;
                    if (block !== snap || block_first !== sf || block_last !== sl) begin
                        errors++;
                        $display("FAIL %s hold_stable first/last got %b%b want %b%b",
                                 name, block_first, block_last, sf, sl);
                    end
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s extra_block got valid=1 want none", name);
                    block_ready = 1'b1;
                    seen        = 1'b0;
                end else begin
                    e   = exp_q.pop_front();
                    bad = -1;
                    for (int i = 15; i >= 0; i--)
                        if (block[1023-64*i -: 64] !== e.data[1023-64*i -: 64])
                            bad = i;
                    checks++;
                    if (bad >= 0) begin
                        errors++;
                        $display("FAIL %s block_word%0d got %h want %h", name, bad,
                                 block[1023-64*bad -: 64], e.data[1023-64*bad -: 64]);
                    end
                    checks++;
                    if (block_first !== e.first || block_last !== e.last) begin
                        errors++;
                        $display("FAIL %s first_last got %b%b want %b%b", name,
                                 block_first, block_last, e.first, e.last);
                    end
                    last_blk    = block;
                    block_ready = 1'b1;
                    seen        = 1'b0;
                end
            end else begin
                block_ready = 1'b0;
            end
        end
        if (cycles >= 4000) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got %0d blocks left want 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        msg_valid   = 1'b0;
        msg_last    = 1'b0;
        block_ready = 1'b0;
        checks++;
        if (msg_ready !== 1'b1 || block_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_fill got ready=%b valid=%b want 1 0",
                     name, msg_ready, block_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (msg_ready !== 1'b1 || block_valid !== 1'b0 || block_first !== 1'b1 ||
            block_last !== 1'b0 || block !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got rdy=%b vld=%b fst=%b lst=%b err=%b want 1 0 1 0 0",
                     msg_ready, block_valid, block_first, block_last, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_abc;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        run_msg("abc", 3, 0, -1);
        checks++;
        if (last_blk[1023:960] !== 64'h6162_6380_0000_0000 || last_blk[63:0] !== 64'h18) begin
            errors++;
            $display("FAIL abc_words got %h %h want 6162638000000000 18",
                     last_blk[1023:960], last_blk[63:0]);
        end
    endtask

    task automatic test_empty;
        msg.delete();
        run_msg("empty", 0, 0, -1);
        checks++;
        if (last_blk[1023:960] !== 64'h8000_0000_0000_0000 || last_blk[959:0] !== '0) begin
            errors++;
            $display("FAIL empty_words got %h want 8000000000000000", last_blk[1023:960]);
        end
    endtask

    task automatic test_111;
        set_rand_msg(111);
        run_msg("len111", 111, 0, -1);
        checks++;
        if (last_blk[135:128] !== 8'h80 || last_blk[63:0] !== 64'h378) begin
            errors++;
            $display("FAIL len111_words got %h %h want 80 378",
                     last_blk[135:128], last_blk[63:0]);
        end
    endtask

    task automatic test_112;
        set_rand_msg(112);
        run_msg("len112", 112, 0, -1);
        checks++;
        if (last_blk[1023:64] !== '0 || last_blk[63:0] !== 64'h380) begin
            errors++;
            $display("FAIL len112_block2 got %h want 380", last_blk[63:0]);
        end
    endtask

    task automatic test_stall;
        set_rand_msg(128);
        run_msg("stall128", 128, 5, -1);
        checks++;
        if (last_blk[1023:960] !== 64'h8000_0000_0000_0000 || last_blk[63:0] !== 64'h400) begin
            errors++;
            $display("FAIL stall128_block2 got %h %h want 8000000000000000 400",
                     last_blk[1023:960], last_blk[63:0]);
        end
    endtask

    task automatic test_back_to_back;
        int lens[6] = '{200, 7, 8, 120, 127, 119};
        foreach (lens[i]) begin
            set_rand_msg(lens[i]);
            run_msg($sformatf("b2b_len%0d", lens[i]), lens[i], i % 3, -1);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        @(negedge clk);
        msg_data  = 64'h4100_0000_0000_0000;
        msg_valid = 1'b1;
        msg_last  = 1'b1;
        msg_bytes = 4'd1;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        checks++;
        if (msg_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_pad_busy got ready=%b want 0", msg_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (msg_ready !== 1'b1 || block_valid !== 1'b0 || block_first !== 1'b1 ||
            block_last !== 1'b0 || block !== '0) begin
            errors++;
            $display("FAIL reset_in_pad got rdy=%b vld=%b fst=%b want 1 0 1",
                     msg_ready, block_valid, block_first);
        end
        msg_valid = 1'b1;
        msg_last  = 1'b1;
        msg_bytes = 4'd5;
        msg_data  = 64'h1122_3344_5566_7788;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        cyc = 0;
        while (!block_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!block_valid) begin
            errors++;
            $display("FAIL reach_emit got valid=0 want 1");
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (msg_ready !== 1'b1 || block_valid !== 1'b0 || block_first !== 1'b1 ||
            block_last !== 1'b0 || block !== '0) begin
            errors++;
            $display("FAIL reset_in_emit got rdy=%b vld=%b fst=%b lst=%b want 1 0 1 0",
                     msg_ready, block_valid, block_first, block_last);
        end
        test_abc();
    endtask

    task automatic test_bytes_over8;
        logic exp_err;
`ifdef SHA512_PADDER_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        set_rand_msg(8);
        run_msg("bytes9", 8, 0, 9);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_flag got %b want %b", err, exp_err);
        end
        set_rand_msg(5);
        run_msg("after_err", 5, 0, -1);
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL err_sticky got %b want %b", err, exp_err);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_reset got %b want 0", err);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        msg_data    = '0;
        msg_valid   = 1'b0;
        msg_last    = 1'b0;
        msg_bytes   = '0;
        block_ready = 1'b0;
        last_blk    = '0;
        test_reset();
        test_abc();
        test_empty();
        test_111();
        test_112();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_bytes_over8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
